// File: rtl/lamp_pattern_decoder.sv
// Four-lamp sequencer receiver: samples the active-low lamp lines, qualifies
// each pattern by stability, decodes it to a position and reports moves.
module lamp_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R,
  input  logic             RC,
  input  logic             LC,
  input  logic             L,
  output logic [1:0]       pos,
  output logic             valid,
  output logic             err,
  output logic             step_r,
  output logic             step_l,
  output logic             skip,
  output logic [CNT_W-1:0] moves
);

  localparam int                STAB_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic [3:0]       r_s;      // sampled lamps, active-high {L,LC,RC,R}
  logic [3:0]       r_cand;   // pattern currently being qualified
  logic [STAB_W-1:0] r_stab;  // cycles the candidate has held so far
  logic             r_acc;    // candidate already accepted

  logic [1:0]       r_pos;
  logic             r_valid;
  logic             r_err;
  logic             r_step_r;
  logic             r_step_l;
  logic             r_skip;
  logic [CNT_W-1:0] r_moves;

  logic             w_accept;
  logic             w_onehot;
  logic [1:0]       w_p;
  logic [2:0]       w_diff;

  assign pos    = r_pos;
  assign valid  = r_valid;
  assign err    = r_err;
  assign step_r = r_step_r;
  assign step_l = r_step_l;
  assign skip   = r_skip;
  assign moves  = r_moves;

  // Candidate becomes accepted on the edge its stability count completes.
  assign w_accept = (r_s == r_cand) && !r_acc && (r_stab == STAB_LAST);

  // Signed 3-bit distance from the current position to the candidate position.
  assign w_diff = {1'b0, w_p} - {1'b0, r_pos};

  // Decode the candidate into a position, flagging anything not one-hot.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    w_onehot = 1'b0;
    w_p      = 2'd0;
    case (r_cand)
      4'b0001: begin w_onehot = 1'b1; w_p = 2'd0; end
      4'b0010: begin w_onehot = 1'b1; w_p = 2'd1; end
      4'b0100: begin w_onehot = 1'b1; w_p = 2'd2; end
      4'b1000: begin w_onehot = 1'b1; w_p = 2'd3; end
      default: begin w_onehot = 1'b0; w_p = 2'd0; end
    endcase
  end

  // Sample the lamp lines into an active-high vector.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of block ordering.
    if (reset) r_s <= 4'b0000;
    else       r_s <= ~{L, LC, RC, R};
  end

  // Stability qualification: any change restarts, a held pattern is accepted once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= 4'b0000;
      r_stab <= '0;
      r_acc  <= 1'b1;
    end else if (r_s != r_cand) begin
      r_cand <= r_s;
      r_stab <= '0;
      r_acc  <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= 1'b1;
    end else if (!r_acc) begin
      r_stab <= r_stab + 1'b1;
    end
  end

  // Registered position, status, one-cycle move pulses and saturating move count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos    <= 2'd0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_step_r <= 1'b0;
      r_step_l <= 1'b0;
      r_skip   <= 1'b0;
      r_moves  <= '0;
    end else begin
      r_step_r <= 1'b0;
      r_step_l <= 1'b0;
      r_skip   <= 1'b0;
      if (w_accept) begin
        if (w_onehot) begin
          r_valid <= 1'b1;
          r_err   <= 1'b0;
          r_pos   <= w_p;
          // A move is only reported relative to a previously valid position.
          if (r_valid && (w_p != r_pos)) begin
            if (w_diff == 3'd1)        r_step_l <= 1'b1;
            else if (w_diff == 3'b111) r_step_r <= 1'b1;
            else                       r_skip   <= 1'b1;
            if (!(&r_moves)) r_moves <= r_moves + 1'b1;
          end
        end else begin
          r_valid <= 1'b0;
          r_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lamp_pattern_decoder.sv
// Bench for lamp_pattern_decoder: three instances (default, 2-bit counter,
// single-cycle qualification) share the lamp inputs and are compared every
// cycle against a run-length based reference model.
module tb_lamp_pattern_decoder;

  localparam int NDUT    = 3;
  localparam int RUN_CAP = 1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic R, RC, LC, L;

  logic [1:0] pos_a, pos_b, pos_c;
  logic       valid_a, valid_b, valid_c;
  logic       err_a, err_b, err_c;
  logic       sr_a, sr_b, sr_c;
  logic       sl_a, sl_b, sl_c;
  logic       sk_a, sk_b, sk_c;
  logic [7:0] moves_a, moves_c;
  logic [1:0] moves_b;

  lamp_pattern_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .R(R), .RC(RC), .LC(LC), .L(L),
    .pos(pos_a), .valid(valid_a), .err(err_a), .step_r(sr_a), .step_l(sl_a),
    .skip(sk_a), .moves(moves_a)
  );

  lamp_pattern_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .R(R), .RC(RC), .LC(LC), .L(L),
    .pos(pos_b), .valid(valid_b), .err(err_b), .step_r(sr_b), .step_l(sl_b),
    .skip(sk_b), .moves(moves_b)
  );

  lamp_pattern_decoder #(.STABLE_CYCLES(1), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .R(R), .RC(RC), .LC(LC), .L(L),
    .pos(pos_c), .valid(valid_c), .err(err_c), .step_r(sr_c), .step_l(sl_c),
    .skip(sk_c), .moves(moves_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: a pattern is accepted when its run of identical samples
  // reaches STABLE_CYCLES+1 edges; reset starts an already-accepted all-off run.
  logic [3:0] m_s     [NDUT];
  int         m_run   [NDUT];
  int         m_pos   [NDUT];
  bit         m_valid [NDUT];
  bit         m_err   [NDUT];
  bit         m_sr    [NDUT];
  bit         m_sl    [NDUT];
  bit         m_sk    [NDUT];
  int         m_moves [NDUT];

  function automatic int stable_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int max_moves_of(input int k);
    return (k == 1) ? 3 : 255;
  endfunction

  task automatic model_accept(input int k, input logic [3:0] v);
    int p;
    int d;
    if ($countones(v) == 1) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (v[i]) p = i;
      if (m_valid[k] && p != m_pos[k]) begin
        d = p - m_pos[k];
        if (d == 1)       m_sl[k] = 1'b1;
        else if (d == -1) m_sr[k] = 1'b1;
        else              m_sk[k] = 1'b1;
        if (m_moves[k] < max_moves_of(k)) m_moves[k]++;
      end
      m_valid[k] = 1'b1;
      m_err[k]   = 1'b0;
      m_pos[k]   = p;
    end else begin
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b1;
    end
  endtask

  task automatic model_edge(input int k, input bit rst, input logic [3:0] lit);
    if (rst) begin
      m_s[k] = 4'b0000; m_run[k] = RUN_CAP;
      m_pos[k] = 0; m_valid[k] = 1'b0; m_err[k] = 1'b0;
      m_sr[k] = 1'b0; m_sl[k] = 1'b0; m_sk[k] = 1'b0; m_moves[k] = 0;
    end else begin
      m_sr[k] = 1'b0; m_sl[k] = 1'b0; m_sk[k] = 1'b0;
      if (m_run[k] == stable_of(k) + 1) model_accept(k, m_s[k]);
      if (lit == m_s[k]) begin
        if (m_run[k] < RUN_CAP) m_run[k]++;
      end else begin
        m_s[k]   = lit;
        m_run[k] = 1;
      end
    end
  endtask

  function automatic logic [31:0] expected_of(input int k);
    logic [7:0] mv;
    logic [1:0] p;
    mv = 8'(m_moves[k]);
    p  = 2'(m_pos[k]);
    return {17'd0, mv, m_sk[k], m_sl[k], m_sr[k], m_err[k], m_valid[k], p};
  endfunction

  function automatic string label(input string base, input int cyc);
    return $sformatf("%s@%0d", base, cyc);
  endfunction

  int cycle_no = 0;

  // One clock: drive inputs (at negedge), advance model at posedge, compare at next negedge.
  task automatic do_cycle(input logic [3:0] lit, input bit rst);
    reset = rst;
    {L, LC, RC, R} = ~lit;
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_edge(k, rst, lit);
    @(negedge clk);
    cycle_no++;
    check(label("sc4_w8", cycle_no),
          {17'd0, moves_a, sk_a, sl_a, sr_a, err_a, valid_a, pos_a}, expected_of(0));
    check(label("sc4_w2", cycle_no),
          {17'd0, 6'd0, moves_b, sk_b, sl_b, sr_b, err_b, valid_b, pos_b}, expected_of(1));
    check(label("sc1_w8", cycle_no),
          {17'd0, moves_c, sk_c, sl_c, sr_c, err_c, valid_c, pos_c}, expected_of(2));
  endtask

  task automatic hold(input logic [3:0] lit, input int cycles);
    for (int i = 0; i < cycles; i++) do_cycle(lit, 1'b0);
  endtask

  initial begin
    logic [3:0] lit;
    int         len;
    reset = 1'b1;
    {L, LC, RC, R} = 4'b1111;
    @(negedge clk);

    // Reset state, then directed walk through the documented scenarios.
    do_cycle(4'b0000, 1'b1);
    do_cycle(4'b0000, 1'b1);
    hold(4'b0000, 8);                 // all-off after reset is never reported
    hold(4'b0001, 8);                 // first valid: pos 0, no pulse
    hold(4'b0010, 8);                 // step_l
    hold(4'b0001, 8);                 // step_r
    hold(4'b1000, 8);                 // skip to 3
    hold(4'b0100, 3);                 // too short, ignored
    hold(4'b1000, 8);                 // same position again, no pulse
    hold(4'b1001, 8);                 // two lamps: err, pos holds
    hold(4'b0100, 8);                 // recovery: no pulse, no count
    hold(4'b0010, 3);                 // mid-qualification
    do_cycle(4'b0010, 1'b1);          // reset discards it
    hold(4'b0010, 8);                 // re-qualifies with full latency
    hold(4'b0000, 8);                 // zero lamps: err
    for (int i = 0; i < 5; i++) begin // saturation of the 2-bit counter
      hold(4'b0001, 7);
      hold(4'b0010, 7);
    end

    // Randomized segments: mostly one-hot patterns of random length, some glitches,
    // invalid patterns and occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(39) == 0) begin
        do_cycle(4'($urandom_range(15)), 1'b1);
      end else begin
        if ($urandom_range(9) < 7) lit = 4'b0001 << $urandom_range(3);
        else                       lit = 4'($urandom_range(15));
        len = $urandom_range(8, 1);
        hold(lit, len);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
